cancid_ctx_mgr: RTL and testbench

- Parametrised per-stream context manager for one regex DFA in the packet inspection engine.
- Saves and restores DFA state per stream ID.
- Tracks which stream IDs have been seen internally, so no external new-stream flag is needed.
- Keeps a per-stream match counter with a readback port.
- Drains the DFA pipeline before committing state at EOP, which closes the EOP-versus-in-flight-character hazard.
- Sits between the packet parser and an external DFA instance.

---
 rtl/cancid_ctx_mgr.sv | 174 +++++++++++++++++
 tb/tb_cancid_ctx_mgr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cancid_ctx_mgr.sv
// cancid_ctx_mgr: per-stream DFA context manager (save/restore state, seen-stream tracking, match counters)
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   sop_i, stream_id_i        start of packet and its stream ID
//   enable_i                  regex enabled for the stream, sampled with eop_i
//   char_in_i, char_in_vld_i  payload byte stream from the parser
//   eop_i                     end of packet (may coincide with the last byte)
//   clr_ctx_i                 forget all streams and zero all counters
//   busy_o                    sop_i/clr_ctx_i ignored while high
//   drop_err_o                pulse: byte, sop or eop outside its legal state
//   fired_o                   current packet matched at least once
//   rd_sid_i, rd_count_o      counter readback, one cycle latency
//   dfa_char_o/_vld_o         byte to the DFA
//   dfa_state_in_o/_vld_o     restored state and load strobe to the DFA
//   dfa_state_out_i           DFA current state
//   dfa_accept_i              DFA accept
// Build option: CANCID_CTX_SAT_EN makes the match counters saturate instead of wrap.
module cancid_ctx_mgr #(
    parameter int STATE_W     = 11,
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = 6,
    parameter int CNT_W       = 16,
    parameter int DFA_LAT     = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               sop_i,
    input  logic [SID_W-1:0]   stream_id_i,
    input  logic               enable_i,
    input  logic [7:0]         char_in_i,
    input  logic               char_in_vld_i,
    input  logic               eop_i,
    input  logic               clr_ctx_i,
    output logic               busy_o,
    output logic               drop_err_o,
    output logic               fired_o,
    input  logic [SID_W-1:0]   rd_sid_i,
    output logic [CNT_W-1:0]   rd_count_o,
    output logic [7:0]         dfa_char_o,
    output logic               dfa_char_vld_o,
    output logic [STATE_W-1:0] dfa_state_in_o,
    output logic               dfa_state_in_vld_o,
    input  logic [STATE_W-1:0] dfa_state_out_i,
    input  logic               dfa_accept_i
);
    localparam int DW = $clog2(DFA_LAT + 2);

    typedef enum logic [2:0] {CLEAR, IDLE, LOAD, RESTORE, ACTIVE, DRAIN, COMMIT} state_e;

    state_e                 state_q;
    logic [SID_W-1:0]       addr_q, sid_q;
    logic [NUM_STREAMS-1:0] valid_q;
    logic [DW-1:0]          dr_q;
    logic [DFA_LAT-1:0]     vp_q;
    logic                   busy_q, drop_q, fired_q, fired_d, en_q, acc_q;
    logic                   char_vld_q, sin_vld_q;
    logic [7:0]             char_q;
    logic [STATE_W-1:0]     sin_q;
    logic [CNT_W-1:0]       rd_count_q, cnt_q, cnt_inc, cnt_wd;
    logic [SID_W-1:0]       cnt_wa;
    logic                   cnt_we, st_we;

    logic [STATE_W-1:0] st_mem  [NUM_STREAMS];
    logic [CNT_W-1:0]   cnt_mem [NUM_STREAMS];

    // The last byte's accept lands in the COMMIT cycle, so the count uses fired_d, not fired_q.
    always_comb begin
        fired_d = (state_q == IDLE && sop_i && !clr_ctx_i) ? 1'b0 :
                  (state_q == COMMIT && !en_q)             ? 1'b0 :
                  (state_q inside {ACTIVE, DRAIN, COMMIT}) ? (fired_q | acc_q) : fired_q;
    end

`ifdef CANCID_CTX_SAT_EN
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(fired_d);
`else
    assign cnt_inc = cnt_q + CNT_W'(fired_d);
`endif

    assign st_we  = rst_n_i && state_q == COMMIT && en_q;
    assign cnt_we = rst_n_i && (state_q == CLEAR || (state_q == COMMIT && en_q));
    assign cnt_wa = (state_q == CLEAR) ? addr_q : sid_q;
    assign cnt_wd = (state_q == CLEAR) ? '0 : cnt_inc;

    always_ff @(posedge clk_i) begin
        if (cnt_we) cnt_mem[cnt_wa] <= cnt_wd;
        if (st_we) st_mem[sid_q] <= dfa_state_out_i;
        cnt_q <= cnt_mem[sid_q];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= CLEAR;
            addr_q     <= '0;
            sid_q      <= '0;
            valid_q    <= '0;
            dr_q       <= '0;
            vp_q       <= '0;
            busy_q     <= 1'b1;
            drop_q     <= 1'b0;
            fired_q    <= 1'b0;
            en_q       <= 1'b0;
            acc_q      <= 1'b0;
            char_vld_q <= 1'b0;
            sin_vld_q  <= 1'b0;
            char_q     <= '0;
            sin_q      <= '0;
            rd_count_q <= '0;
        end else begin
            rd_count_q <= cnt_mem[rd_sid_i];
            char_q     <= char_in_i;
            char_vld_q <= char_in_vld_i && state_q == ACTIVE;
            sin_vld_q  <= state_q == LOAD;
            // Accept only counts when it follows a forwarded byte; a freshly loaded accepting state is not a match.
            vp_q       <= DFA_LAT'({vp_q, char_vld_q});
            acc_q      <= dfa_accept_i && vp_q[DFA_LAT-1];
            drop_q     <= (char_in_vld_i && state_q != ACTIVE) || (eop_i && state_q != ACTIVE) ||
                          (sop_i && (state_q != IDLE || clr_ctx_i));
            fired_q    <= fired_d;
            busy_q     <= 1'b1;
            case (state_q)
                CLEAR: begin
                    addr_q <= addr_q + SID_W'(1);
                    if (addr_q == SID_W'(NUM_STREAMS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr_ctx_i) begin
                        state_q <= CLEAR;
                        addr_q  <= '0;
                        valid_q <= '0;
                    end else if (sop_i) begin
                        sid_q   <= stream_id_i;
                        state_q <= LOAD;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                LOAD: begin
                    sin_q   <= valid_q[sid_q] ? st_mem[sid_q] : '0;
                    state_q <= RESTORE;
                end
                RESTORE: state_q <= ACTIVE;
                ACTIVE: begin
                    if (eop_i) begin
                        en_q    <= enable_i;
                        dr_q    <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    dr_q <= dr_q + DW'(1);
                    if (dr_q == DW'(DFA_LAT)) state_q <= COMMIT;
                end
                COMMIT: begin
                    if (en_q) valid_q[sid_q] <= 1'b1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign busy_o             = busy_q;
    assign drop_err_o         = drop_q;
    assign fired_o            = fired_q;
    assign rd_count_o         = rd_count_q;
    assign dfa_char_o         = char_q;
    assign dfa_char_vld_o     = char_vld_q;
    assign dfa_state_in_o     = sin_q;
    assign dfa_state_in_vld_o = sin_vld_q;
endmodule

// File: tb/tb_cancid_ctx_mgr.sv
// tb_cancid_ctx_mgr: scoreboard bench for cancid_ctx_mgr with a nibble-shift DFA model
module tb_cancid_ctx_mgr;
    localparam int SW = 11, NS = 64, IW = 6, CW = 2, LAT = 1;
`ifdef CANCID_CTX_SAT_EN
    localparam int SAT_EXP = 3;
`else
    localparam int SAT_EXP = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, sop, enable, char_in_vld, eop, clr_ctx;
    logic          busy, drop_err, fired, dfa_char_vld, dfa_state_in_vld, dfa_accept;
    logic [IW-1:0] stream_id, rd_sid;
    logic [7:0]    char_in, dfa_char;
    logic [CW-1:0] rd_count;
    logic [SW-1:0] dfa_state_in, dfa_state_out;

    cancid_ctx_mgr #(.STATE_W(SW), .NUM_STREAMS(NS), .SID_W(IW), .CNT_W(CW), .DFA_LAT(LAT)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .sop_i(sop), .stream_id_i(stream_id), .enable_i(enable),
        .char_in_i(char_in), .char_in_vld_i(char_in_vld), .eop_i(eop), .clr_ctx_i(clr_ctx),
        .busy_o(busy), .drop_err_o(drop_err), .fired_o(fired), .rd_sid_i(rd_sid), .rd_count_o(rd_count),
        .dfa_char_o(dfa_char), .dfa_char_vld_o(dfa_char_vld), .dfa_state_in_o(dfa_state_in),
        .dfa_state_in_vld_o(dfa_state_in_vld), .dfa_state_out_i(dfa_state_out), .dfa_accept_i(dfa_accept)
    );

    logic [SW-1:0] dst = '0;
    always @(posedge clk)
        if (dfa_state_in_vld) dst <= dfa_state_in;
        else if (dfa_char_vld) dst <= SW'({dst, dfa_char[3:0]});
    assign dfa_state_out = dst;
    assign dfa_accept    = dst == 11'h234;

    int errors = 0, checks = 0, cyc = 0, drop_exp = 0;
    int ld_st[$], ld_cyc[$], chq[$], rdq[$];
    logic rd_req = 1'b0, rd_vld = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_vld <= rd_req;
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) if (rst_n) begin
        if (dfa_state_in_vld) begin
            if (ld_st.size() == 0) chk("unexpected_load", 1, 0);
            else begin
                chk("restore_state", int'(dfa_state_in), ld_st.pop_front());
                chk("load_latency", cyc, ld_cyc.pop_front());
            end
        end
        if (dfa_char_vld) begin
            if (chq.size() == 0) chk("unexpected_char", int'(dfa_char), -1);
            else chk("fwd_char", int'(dfa_char), chq.pop_front());
        end
        if (drop_err) begin
            chk("drop_expected", int'(drop_exp > 0), 1);
            if (drop_exp > 0) drop_exp--;
        end
        if (rd_vld) begin
            if (rdq.size() == 0) chk("unexpected_rd", 1, 0);
            else chk($sformatf("rd_count_sid%0d", rd_sid), int'(rd_count), rdq.pop_front());
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("idle_timeout", n, 0);
    endtask

    task automatic rd(input int sid, input int exp);
        rd_sid = IW'(sid);
        rd_req = 1'b1;
        rdq.push_back(exp);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic pkt(input int sid, input logic [31:0] b, input int n, input logic en,
                       input int exp_ld, input bit rbyte, input bit dsop);
        wait_idle();
        sop = 1'b1;
        stream_id = IW'(sid);
        ld_st.push_back(exp_ld);
        ld_cyc.push_back(cyc + 2);
        tick();
        sop = 1'b0;
        tick();
        if (rbyte) begin
            char_in = 8'hFF;
            char_in_vld = 1'b1;
            drop_exp++;
        end
        tick();
        char_in_vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            char_in = b[8*i+:8];
            char_in_vld = 1'b1;
            chq.push_back(int'(b[8*i+:8]));
            if (i == n - 1) begin
                eop = 1'b1;
                enable = en;
            end
            tick();
        end
        char_in_vld = 1'b0;
        eop = 1'b0;
        enable = 1'b0;
        if (dsop) begin
            sop = 1'b1;
            stream_id = IW'(sid ^ 1);
            drop_exp++;
            tick();
            sop = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; sop = 1'b0; stream_id = '0; enable = 1'b0; char_in = '0; char_in_vld = 1'b0;
        eop = 1'b0; clr_ctx = 1'b0; rd_sid = '0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 1);
        chk("rst_fired", int'(fired), 0);
        chk("rst_drop", int'(drop_err), 0);
        chk("rst_char_vld", int'(dfa_char_vld), 0);
        chk("rst_sin_vld", int'(dfa_state_in_vld), 0);
        chk("rst_char", int'(dfa_char), 0);
        chk("rst_sin", int'(dfa_state_in), 0);
        chk("rst_rd_count", int'(rd_count), 0);
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        chk("busy_cycles", n, 64);
        for (int s = 0; s < NS; s++) rd(s, 0);

        pkt(5, 32'h00030201, 3, 1'b1, 0, 0, 0);
        chk("fired_new_stream", int'(fired), 0);
        rd(5, 0);

        pkt(5, 32'h00000004, 1, 1'b1, 'h123, 0, 0);
        chk("fired_resume", int'(fired), 1);
        rd(5, 1);

        pkt(9, 32'h04030201, 4, 1'b0, 0, 0, 0);
        chk("fired_disabled", int'(fired), 0);
        rd(9, 0);
        pkt(9, 32'h00000001, 1, 1'b0, 0, 0, 0);

        pkt(7, 32'h00000001, 1, 1'b1, 0, 1, 1);
        char_in = 8'hEE; char_in_vld = 1'b1; drop_exp++;
        tick();
        char_in_vld = 1'b0; eop = 1'b1; drop_exp++;
        tick();
        eop = 1'b0;
        tick();
        chk("idle_after_errors", int'(busy), 0);

        pkt(1, 32'h04030201, 4, 1'b1, 0, 0, 0);
        pkt(1, 32'h04030201, 4, 1'b1, 'h234, 0, 0);
        pkt(1, 32'h04030201, 4, 1'b1, 'h234, 0, 0);
        rd(1, 3);
        pkt(1, 32'h04030201, 4, 1'b1, 'h234, 0, 0);
        chk("fired_sat_pkt", int'(fired), 1);
        rd(1, SAT_EXP);

        clr_ctx = 1'b1; sop = 1'b1; stream_id = 6'd1; drop_exp++;
        tick();
        clr_ctx = 1'b0; sop = 1'b0;
        chk("busy_after_clr", int'(busy), 1);
        wait_idle();
        rd(1, 0);
        rd(5, 0);
        pkt(1, 32'h00000001, 1, 1'b1, 0, 0, 0);

        repeat (5) tick();
        chk("load_queue_empty", ld_st.size(), 0);
        chk("char_queue_empty", chq.size(), 0);
        chk("rd_queue_empty", rdq.size(), 0);
        chk("drops_seen", drop_exp, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
